// File: rtl/regfile_write_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_write_scheduler
//
// Shares the single write port of a 32x32 register file between two writeback
// sources: the ALU (port A) and the load unit (port B). It also keeps a 32-bit
// scoreboard of destination registers that still have a write outstanding, so
// the issue stage can reserve destinations and check its source operands.
//
// Build option:
//   REGFILE_SCHED_RR_EN  defined   -> round-robin arbitration when both ports
//                                     request in the same cycle
//                        undefined -> fixed priority, the load unit (B) wins
//
// Ports:
//   Clk, Reset                      clock, synchronous active-high reset
//   ReqValidA/B, ReqRegA/B,
//   ReqDataA/B                      writeback requests (ALU / load unit)
//   ReqReadyA/B                     grants; accept = valid & ready on an edge
//   ReserveValid, ReserveReg        issue-stage destination claim
//   ReserveReady                    claim can be taken this cycle
//   ReadRegister1/2                 source operands to check
//   Busy1/Busy2                     source operand has a write outstanding
//   WriteData, WriteRegister,
//   RegWrite                        register file write port
// -----------------------------------------------------------------------------
module regfile_write_scheduler (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValidA,
  input  logic [4:0]  ReqRegA,
  input  logic [31:0] ReqDataA,
  output logic        ReqReadyA,
  input  logic        ReqValidB,
  input  logic [4:0]  ReqRegB,
  input  logic [31:0] ReqDataB,
  output logic        ReqReadyB,
  input  logic        ReserveValid,
  input  logic [4:0]  ReserveReg,
  output logic        ReserveReady,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  output logic        Busy1,
  output logic        Busy2,
  output logic [31:0] WriteData,
  output logic [4:0]  WriteRegister,
  output logic        RegWrite
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  port_e              last_grant_q, last_grant_d;
  logic               reg_write_q,  reg_write_d;
  logic [ADDR_W-1:0]  write_reg_q,  write_reg_d;
  logic [DATA_W-1:0]  write_data_q, write_data_d;
  logic [NREGS-1:0]   busy_q,       busy_d;

  logic grant_a;
  logic grant_b;
  logic reserve_ready;

  // Arbitration: purely combinational from the two valids and LastGrant.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!Reset) begin
      if (ReqValidA && ReqValidB) begin
`ifdef REGFILE_SCHED_RR_EN
        // The port that did not win last time goes now.
        if (last_grant_q == PORT_B) grant_a = 1'b1;
        else                        grant_b = 1'b1;
`else
        grant_b = 1'b1;
`endif
      end else begin
        grant_a = ReqValidA;
        grant_b = ReqValidB;
      end
    end
  end

  // Bit 0 of the scoreboard is always clear, so register 0 is always claimable.
  assign reserve_ready = !Reset && !busy_q[ReserveReg];

  assign ReqReadyA     = grant_a;
  assign ReqReadyB     = grant_b;
  assign ReserveReady  = reserve_ready;
  assign Busy1         = busy_q[ReadRegister1];
  assign Busy2         = busy_q[ReadRegister2];
  assign WriteData     = write_data_q;
  assign WriteRegister = write_reg_q;
  assign RegWrite      = reg_write_q;

  // Next state for the output stage and the scoreboard.
  always_comb begin
    last_grant_d = last_grant_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    busy_d       = busy_q;

    if (grant_a) begin
      write_reg_d  = ReqRegA;
      write_data_d = ReqDataA;
      reg_write_d  = (ReqRegA != '0);
      last_grant_d = PORT_A;
    end else if (grant_b) begin
      write_reg_d  = ReqRegB;
      write_data_d = ReqDataB;
      reg_write_d  = (ReqRegB != '0);
      last_grant_d = PORT_B;
    end

    // Commit clears first so that a reservation on the same edge wins.
    if (reg_write_q) busy_d[write_reg_q] = 1'b0;
    if (ReserveValid && reserve_ready && (ReserveReg != '0))
      busy_d[ReserveReg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_grant_q <= PORT_B;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_scheduler
//
// Self-checking bench for regfile_write_scheduler. A behavioural model (busy
// bit vector, last granted port, output-stage registers) is stepped once per
// clock alongside the DUT; directed scenarios are followed by random traffic.
// Honours REGFILE_SCHED_RR_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_regfile_write_scheduler;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValidA, ReqValidB;
  logic [4:0]  ReqRegA, ReqRegB;
  logic [31:0] ReqDataA, ReqDataB;
  logic        ReqReadyA, ReqReadyB;
  logic        ReserveValid;
  logic [4:0]  ReserveReg;
  logic        ReserveReady;
  logic [4:0]  ReadRegister1, ReadRegister2;
  logic        Busy1, Busy2;
  logic [31:0] WriteData;
  logic [4:0]  WriteRegister;
  logic        RegWrite;

  always #5 Clk = ~Clk;

  regfile_write_scheduler dut (
    .Clk(Clk), .Reset(Reset),
    .ReqValidA(ReqValidA), .ReqRegA(ReqRegA), .ReqDataA(ReqDataA), .ReqReadyA(ReqReadyA),
    .ReqValidB(ReqValidB), .ReqRegB(ReqRegB), .ReqDataB(ReqDataB), .ReqReadyB(ReqReadyB),
    .ReserveValid(ReserveValid), .ReserveReg(ReserveReg), .ReserveReady(ReserveReady),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .Busy1(Busy1), .Busy2(Busy2),
    .WriteData(WriteData), .WriteRegister(WriteRegister), .RegWrite(RegWrite)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: which registers have a write outstanding, the
  // port served last (1 = B), and what the write port is presenting.
  logic [31:0] m_busy;
  logic        m_last;
  logic        m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  logic        m_ga, m_gb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = '0; m_last = 1'b1; m_rw = 1'b0; m_wr = '0; m_wd = '0;
    m_ga = 1'b0; m_gb = 1'b0;
  endtask

  // Compare everything against the model for the current inputs, advance the
  // model across the coming edge, and return on the following falling edge.
  task automatic tick();
    logic        ga, gb, rr;
    logic [31:0] busy_old;
    #1;
    ga = 1'b0; gb = 1'b0;
    if (!Reset) begin
      if (ReqValidA && ReqValidB) begin
`ifdef REGFILE_SCHED_RR_EN
        ga = m_last;  gb = !m_last;
`else
        gb = 1'b1;
`endif
      end else begin
        ga = ReqValidA; gb = ReqValidB;
      end
    end
    rr = !Reset && ((ReserveReg == 5'd0) || !m_busy[ReserveReg]);

    chk("readyA",   {31'b0, ReqReadyA},    {31'b0, ga});
    chk("readyB",   {31'b0, ReqReadyB},    {31'b0, gb});
    chk("rsv_rdy",  {31'b0, ReserveReady}, {31'b0, rr});
    chk("busy1",    {31'b0, Busy1},        {31'b0, m_busy[ReadRegister1]});
    chk("busy2",    {31'b0, Busy2},        {31'b0, m_busy[ReadRegister2]});
    chk("regwrite", {31'b0, RegWrite},     {31'b0, m_rw});
    chk("wreg",     {27'b0, WriteRegister},{27'b0, m_wr});
    chk("wdata",    WriteData,             m_wd);

    if (Reset) begin
      model_reset();
    end else begin
      busy_old = m_busy;
      if (m_rw) m_busy[m_wr] = 1'b0;
      if (ReserveValid && rr && ReserveReg != 5'd0) m_busy[ReserveReg] = 1'b1;
      if (ga) begin
        m_wr = ReqRegA; m_wd = ReqDataA; m_rw = (ReqRegA != 0); m_last = 1'b0;
      end else if (gb) begin
        m_wr = ReqRegB; m_wd = ReqDataB; m_rw = (ReqRegB != 0); m_last = 1'b1;
      end else begin
        m_rw = 1'b0;
      end
      m_ga = ga; m_gb = gb;
      if (busy_old[0]) m_busy[0] = 1'b0;
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    ReqValidA = 0; ReqValidB = 0; ReserveValid = 0;
    ReqRegA = 0; ReqRegB = 0; ReqDataA = 0; ReqDataB = 0;
    ReserveReg = 0; ReadRegister1 = 0; ReadRegister2 = 0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  int wait_a, wait_b;

  initial begin
    idle_inputs();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    model_reset();
    chk("rst_regwrite", {31'b0, RegWrite}, 32'd0);
    chk("rst_wreg",     {27'b0, WriteRegister}, 32'd0);
    chk("rst_wdata",    WriteData, 32'd0);
    chk("rst_readyA",   {31'b0, ReqReadyA}, 32'd0);
    Reset = 1'b0;

    // A alone: reg 5 <- DEADBEEF.
    ReqValidA = 1; ReqRegA = 5'd5; ReqDataA = 32'hDEADBEEF;
    #1 chk("a_alone_ready", {31'b0, ReqReadyA}, 32'd1);
    tick();
    ReqValidA = 0;
    chk("a_alone_rw",    {31'b0, RegWrite}, 32'd1);
    chk("a_alone_wreg",  {27'b0, WriteRegister}, 32'd5);
    chk("a_alone_wdata", WriteData, 32'hDEADBEEF);
    tick();
    chk("a_alone_rw_off", {31'b0, RegWrite}, 32'd0);

    // Contention for 4 cycles, starting from reset state (A wins first under RR).
    do_reset();
    ReqValidA = 1; ReqRegA = 5'd3; ReqDataA = 32'h33;
    ReqValidB = 1; ReqRegB = 5'd4; ReqDataB = 32'h44;
    for (int i = 0; i < 4; i++) begin
      #1;
`ifdef REGFILE_SCHED_RR_EN
      chk("rr_readyA", {31'b0, ReqReadyA}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_readyB", {31'b0, ReqReadyB}, (i % 2 == 0) ? 32'd0 : 32'd1);
`else
      chk("fp_readyA", {31'b0, ReqReadyA}, 32'd0);
      chk("fp_readyB", {31'b0, ReqReadyB}, 32'd1);
`endif
      tick();
      chk("contend_rw", {31'b0, RegWrite}, 32'd1);
    end
    ReqValidA = 0; ReqValidB = 0;
    tick();

    // Scoreboard: reserve 7, observe busy, commit clears it.
    ReserveValid = 1; ReserveReg = 5'd7; ReadRegister1 = 5'd7;
    tick();
    ReserveValid = 0;
    #1;
    chk("sb_busy1_set",  {31'b0, Busy1}, 32'd1);
    chk("sb_rsv_blocked", {31'b0, ReserveReady}, 32'd0);
    ReqValidA = 1; ReqRegA = 5'd7; ReqDataA = 32'h77;
    tick();
    ReqValidA = 0;
    chk("sb_busy_pending", {31'b0, Busy1}, 32'd1);
    tick();
    chk("sb_busy1_clear", {31'b0, Busy1}, 32'd0);

    // Unreserved write to 7, with a reservation of 7 on its commit edge.
    ReqValidA = 1; ReqRegA = 5'd7; ReqDataA = 32'h777;
    tick();
    ReqValidA = 0;
    ReserveValid = 1; ReserveReg = 5'd7;
    tick();
    ReserveValid = 0;
    chk("sb_set_wins", {31'b0, Busy1}, 32'd1);

    // Write to register 0: accepted, then dropped.
    ReqValidB = 1; ReqRegB = 5'd0; ReqDataB = 32'h12345678; ReadRegister2 = 5'd0;
    #1 chk("r0_ready", {31'b0, ReqReadyB}, 32'd1);
    tick();
    ReqValidB = 0;
    chk("r0_rw",    {31'b0, RegWrite}, 32'd0);
    chk("r0_busy2", {31'b0, Busy2}, 32'd0);

    // Reset in the middle of a pending write.
    do_reset();
    ReserveValid = 1; ReserveReg = 5'd1;
    tick();
    ReserveReg = 5'd2;
    tick();
    ReserveValid = 0;
    ReqValidA = 1; ReqRegA = 5'd1; ReqDataA = 32'h11;
    tick();
    ReqValidB = 1; ReqRegB = 5'd9;
    Reset = 1;
    ReadRegister1 = 5'd1; ReadRegister2 = 5'd2;
    #1;
    chk("rst_mid_readyA", {31'b0, ReqReadyA}, 32'd0);
    chk("rst_mid_readyB", {31'b0, ReqReadyB}, 32'd0);
    chk("rst_mid_rsv",    {31'b0, ReserveReady}, 32'd0);
    tick();
    Reset = 0;
    ReqValidA = 0; ReqValidB = 0;
    #1;
    chk("rst_mid_rw",    {31'b0, RegWrite}, 32'd0);
    chk("rst_mid_busy1", {31'b0, Busy1}, 32'd0);
    chk("rst_mid_busy2", {31'b0, Busy2}, 32'd0);
    tick();

    // Random traffic. A refused request is held stable until granted.
    wait_a = 0; wait_b = 0;
    for (int i = 0; i < 3000; i++) begin
      Reset = ($urandom_range(0, 199) == 0);
      if (!(ReqValidA && !m_ga)) begin
        ReqValidA = ($urandom_range(0, 1) == 1);
        ReqRegA   = 5'($urandom_range(0, 7));
        ReqDataA  = $urandom;
      end
      if (!(ReqValidB && !m_gb)) begin
        ReqValidB = ($urandom_range(0, 2) != 0);
        ReqRegB   = 5'($urandom_range(0, 7));
        ReqDataB  = $urandom;
      end
      ReserveValid  = ($urandom_range(0, 4) < 2);
      ReserveReg    = 5'($urandom_range(0, 7));
      ReadRegister1 = 5'($urandom_range(0, 7));
      ReadRegister2 = 5'($urandom_range(0, 31));
      tick();
      if (Reset) begin
        wait_a = 0; wait_b = 0;
        m_ga = 1'b0; m_gb = 1'b0;
      end else begin
        wait_a = (ReqValidA && !m_ga) ? wait_a + 1 : 0;
        wait_b = (ReqValidB && !m_gb) ? wait_b + 1 : 0;
`ifdef REGFILE_SCHED_RR_EN
        chk("fair_a", {31'b0, (wait_a <= 1)}, 32'd1);
`endif
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
